rs_issue_arb: RTL
=================

Name: rs_issue_arb

Overview:
- Responder end of the reservation-station issue handshake.
- Collects per-entry issue requests and packets from NUM_ENTRIES RS entries and returns a one-hot grant the same cycle; a granted entry deallocates on that grant.
- Registers the winning packet into an rs2 output stage feeding execute.
- Round-robin fairness, downstream backpressure, flush.

Parameters:
- NUM_ENTRIES, 8, number of RS entries arbitrated; 2..32.
- PKT_W, 128, width of one flattened t_uinstr_iss issue packet.
- PTR_W, $clog2(NUM_ENTRIES), width of the round-robin pointer; derived, not overridable.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- flush  input  1  pipeline flush; kills the output stage and suppresses grants this cycle.
- e_req_issue_rs1  input  NUM_ENTRIES  per-entry issue request (bit i = entry i).
- e_issue_pkt_rs1  input  NUM_ENTRIES*PKT_W  per-entry issue packet; entry i at bits [i*PKT_W +: PKT_W].
- e_gnt_issue_rs1  output  NUM_ENTRIES  one-hot (or zero) grant, combinational.
- ex_ready  input  1  execute accepts the rs2 packet this cycle.
- iss_valid_rs2  output  1  output stage holds a valid packet.
- iss_pkt_rs2  output  PKT_W  registered issue packet.
- perf_gnt_cnt  output  32  grant counter; 0 when the feature is off.
- perf_stall_cnt  output  32  backpressure-stall counter; 0 when the feature is off.

Behaviour:
- Reset values: iss_valid_rs2=0, iss_pkt_rs2=0, rr_ptr=0, perf counters=0. e_gnt_issue_rs1=0 during any cycle with reset high.
- Slot open: can_issue = ~iss_valid_rs2 | ex_ready. Full-throughput back-to-back issue is supported.
- Grant: if can_issue & ~flush & ~reset & |e_req_issue_rs1, grant the first requesting entry scanning upward from rr_ptr, wrapping NUM_ENTRIES-1 -> 0. Otherwise grant=0.
- Grant properties: at most one bit set. A grant is never asserted to a non-requesting entry. Combinational from req, rr_ptr, iss_valid_rs2, ex_ready, flush.
- Pointer: on a grant to entry g, rr_ptr_nxt = (g==NUM_ENTRIES-1) ? 0 : g+1. Otherwise unchanged, including under flush. Wrap is explicit; NUM_ENTRIES need not be a power of two.
- Output stage, priority order:
  - reset -> valid 0.
  - flush -> valid 0 (packet don't-care, held).
  - grant -> valid 1, pkt = granted entry's packet.
  - ex_ready & valid -> valid 0.
  - otherwise hold.
- Packet capture: iss_pkt_rs2 is loaded only on grant and stays stable while valid & ~ex_ready.
- Latency: request in cycle N -> grant in cycle N -> iss_valid_rs2 in cycle N+1.
- Stall: valid & ~ex_ready -> no grant; requesting entries stay allocated and keep requesting.
- Simultaneous flush + grant conditions: flush wins; no grant, so no entry deallocates.
- No requests: no state change except output drain.
- Reset mid-stall: the output clears next cycle and rr_ptr returns to 0.

Optional Feature:
- Macro: RS_ISSUE_PERF_CNT_EN.
- Defined:
  - perf_gnt_cnt increments on every cycle with |e_gnt_issue_rs1.
  - perf_stall_cnt increments on every cycle with iss_valid_rs2 & ~ex_ready.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: no counter flops are instantiated; both ports are tied to 0.

Test Plan:
- Single request: NUM_ENTRIES=8, req=8'b0000_0100, ex_ready=1 -> gnt=8'b0000_0100 the same cycle; next cycle iss_valid_rs2=1 with pkt = entry 2's packet; rr_ptr=3.
- Round-robin fairness: req=8'hFF held, ex_ready=1 -> grants entry 0,1,...,7,0 on consecutive cycles, one-hot each cycle, with iss_valid_rs2 continuously 1.
- Wrap: rr_ptr=6, req=8'b0000_0011 -> grant entry 0; rr_ptr becomes 1; next-cycle grant is entry 1.
- Backpressure: valid packet present, ex_ready=0 for 3 cycles with req=8'h10 -> gnt=0 for 3 cycles, pkt unchanged; ex_ready=1 -> gnt=8'h10 that cycle; with the feature on, perf_stall_cnt=3.
- Flush collision: req=8'h01, can_issue=1, flush=1 -> gnt=0, iss_valid_rs2=0 next cycle, rr_ptr unchanged; next cycle without flush -> gnt=8'h01.
- Reset mid-operation: reset asserted while iss_valid_rs2=1 and rr_ptr=5 -> gnt=0 during reset; after one cycle iss_valid_rs2=0, rr_ptr=0, and perf counters=0.

Source files
------------

// File: rtl/rs_issue_arb.sv
// Reservation-station issue arbiter: round-robin one-hot grant plus the registered rs2 output stage.
// Optional saturating perf counters are enabled with `define RS_ISSUE_PERF_CNT_EN.
module rs_issue_arb #(
    parameter int  NUM_ENTRIES = 8,
    parameter int  PKT_W       = 128,
    localparam int PTR_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NUM_ENTRIES-1:0]       e_req_issue_rs1,
    input  logic [NUM_ENTRIES*PKT_W-1:0] e_issue_pkt_rs1,
    output logic [NUM_ENTRIES-1:0]       e_gnt_issue_rs1,
    input  logic                         ex_ready,
    output logic                         iss_valid_rs2,
    output logic [PKT_W-1:0]             iss_pkt_rs2,
    output logic [31:0]                  perf_gnt_cnt,
    output logic [31:0]                  perf_stall_cnt
);

    logic [PTR_W-1:0]       r_rr_ptr;
    logic                   r_valid;
    logic [PKT_W-1:0]       r_pkt;

    logic                   w_found;
    logic [PTR_W-1:0]       w_idx;
    logic                   w_can_issue;
    logic                   w_gnt_en;
    logic [NUM_ENTRIES-1:0] w_gnt;
    logic [PKT_W-1:0]       w_pkt;
    logic [PTR_W-1:0]       w_ptr_nxt;

    // Scan upward from the round-robin pointer with an explicit wrap, so non-power-of-two sizes work.
    always_comb begin
        logic [PTR_W:0] v_pos;
        w_found = 1'b0;
        w_idx   = '0;
        v_pos   = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            v_pos = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (v_pos >= (PTR_W+1)'(NUM_ENTRIES)) begin
                v_pos = v_pos - (PTR_W+1)'(NUM_ENTRIES);
            end else begin
                v_pos = v_pos;
            end
            if (!w_found && e_req_issue_rs1[v_pos[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = v_pos[PTR_W-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant qualification, one-hot decode, winner packet select and pointer advance.
    always_comb begin
        w_can_issue = ~r_valid | ex_ready;
        w_gnt_en    = w_can_issue & ~flush & ~reset & w_found;
        w_gnt       = '0;
        w_pkt       = e_issue_pkt_rs1[w_idx*PKT_W +: PKT_W];
        w_ptr_nxt   = r_rr_ptr;
        if (w_gnt_en) begin
            w_gnt[w_idx] = 1'b1;
            if (w_idx == PTR_W'(NUM_ENTRIES-1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = w_idx + PTR_W'(1);
            end
        end else begin
            w_gnt     = '0;
            w_ptr_nxt = r_rr_ptr;
        end
    end

    // Round-robin pointer; a flush leaves it untouched because no grant happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // Output stage: flush beats a new grant, a grant beats draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_gnt_en) begin
            r_valid <= 1'b1;
            r_pkt   <= w_pkt;
        end else if (ex_ready && r_valid) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign e_gnt_issue_rs1 = w_gnt;
    assign iss_valid_rs2   = r_valid;
    assign iss_pkt_rs2     = r_pkt;

`ifdef RS_ISSUE_PERF_CNT_EN
    logic [31:0] r_gnt_cnt;
    logic [31:0] r_stall_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating grant and backpressure-stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_cnt   <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_gnt_cnt   <= w_gnt_en ? sat_inc(r_gnt_cnt) : r_gnt_cnt;
            r_stall_cnt <= (r_valid && !ex_ready) ? sat_inc(r_stall_cnt) : r_stall_cnt;
        end
    end

    assign perf_gnt_cnt   = r_gnt_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`else
    assign perf_gnt_cnt   = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
